bram_fifo_ctrl: RTL and testbench
=================================

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the BRAM depth as 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AFULL_MARGIN, default 4, giving the almost-full threshold as 2^ADDR_WIDTH - AFULL_MARGIN.
REQ-004 Port clk, input, 1 bit: the only clock.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Ports in_data (input, DATA_WIDTH), in_valid (input, 1) and in_ready (output, 1) SHALL form the write-side valid/ready stream.
REQ-007 Ports out_data (output, DATA_WIDTH), out_valid (output, 1) and out_ready (input, 1) SHALL form the read-side valid/ready stream.
REQ-008 Ports bram_en, bram_we (output, 1), bram_write_address, bram_read_address (output, ADDR_WIDTH), bram_data_in (output, DATA_WIDTH) and bram_data_out (input, DATA_WIDTH) SHALL drive an external simple-dual-port BRAM with 2-cycle registered read latency.
REQ-009 Ports fill_level (output, ADDR_WIDTH+1) and almost_full (output, 1) SHALL report occupancy.

Function
REQ-010 A write handshake SHALL be in_valid & in_ready; in that cycle bram_we=1, bram_write_address=wr_ptr, bram_data_in=in_data, and wr_ptr increments at the clock edge.
REQ-011 in_ready SHALL be 1 exactly when the BRAM entry count is below 2^ADDR_WIDTH.
REQ-012 bram_en SHALL be 1 whenever rst is low.
REQ-013 A read SHALL be issued (bram_read_address=rd_ptr, then rd_ptr increments) when the BRAM entry count is nonzero and in-flight reads plus prefetch occupancy is below 3.
REQ-014 A 2-stage valid shift register SHALL tag issued reads; bram_data_out SHALL be captured into the prefetch buffer 2 cycles after issue.
REQ-015 The prefetch buffer SHALL be a 3-entry FIFO; out_valid is 1 exactly when it is non-empty; out_data is its head, registered.
REQ-016 A word accepted in cycle 0 into an empty block SHALL appear with out_valid=1 in cycle 4.
REQ-017 Sustained throughput SHALL be one word per cycle per side when neither side stalls.
REQ-018 A simultaneous write and read issue SHALL leave the entry count unchanged; pointers SHALL wrap modulo 2^ADDR_WIDTH.
REQ-019 A read SHALL never be issued for an entry written in the same cycle.
REQ-020 out_valid, once asserted, SHALL hold with stable out_data until out_ready.
REQ-021 Total capacity SHALL be 2^ADDR_WIDTH + 3 words.

Reset
REQ-022 Asserting rst SHALL immediately clear wr_ptr, rd_ptr, entry count, tags and prefetch buffer, and force in_ready=0, out_valid=0, bram_we=0, bram_en=0, fill_level=0, almost_full=0.
REQ-023 Reset mid-transfer SHALL discard all stored and in-flight words; in_ready SHALL return to 1 in the first cycle after rst deasserts.

Configuration
REQ-024 With BRAM_FIFO_LEVEL_EN defined, fill_level SHALL equal BRAM entries plus in-flight reads plus prefetch occupancy, registered, and almost_full SHALL be fill_level >= 2^ADDR_WIDTH - AFULL_MARGIN.
REQ-025 Without BRAM_FIFO_LEVEL_EN, fill_level and almost_full SHALL be tied to 0 and no level logic synthesised.

Structure
REQ-026 Package bram_fifo_pkg SHALL hold constants BRAM_RD_LATENCY=2 and PREFETCH_DEPTH=3.
REQ-027 The prefetch buffer SHALL be sub-module bram_fifo_prefetch.

Verification
REQ-028 Single word 0xDEADBEEF written in cycle 0, out_ready=1 -> out_valid in cycle 4 with out_data=0xDEADBEEF, then empty.
REQ-029 ADDR_WIDTH=4, out_ready=0, write continuously -> in_ready drops after 19 accepted words; in level build, almost_full=1 from fill_level=12.
REQ-030 Stream 0..99 with both sides randomly stalled -> output exactly 0..99 in order, no duplicates.
REQ-031 Fill, drain and refill across pointer wrap (ADDR_WIDTH=4, 40 words) -> order preserved.
REQ-032 rst pulsed with 5 words stored and 2 in flight -> outputs at reset values within the reset cycle; afterwards empty, in_ready=1.
REQ-033 out_ready toggled every cycle with continuous input -> out_data stable while out_valid & !out_ready.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared constants for the BRAM-backed FIFO controller.
package bram_fifo_pkg;
  localparam int BRAM_RD_LATENCY = 2;
  localparam int PREFETCH_DEPTH  = 3;
  localparam int PF_CNT_W        = 2;
endpackage

// File: rtl/bram_fifo_prefetch.sv
// 3-entry shift FIFO holding words returned by the BRAM; slot 0 is the
// registered head presented on the read-side stream.
module bram_fifo_prefetch
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [PF_CNT_W-1:0]   count
);

  logic [DATA_WIDTH-1:0] slot [PREFETCH_DEPTH];
  logic [PF_CNT_W-1:0]   wr_idx;
  logic [PF_CNT_W-1:0]   count_nxt;

  always_comb begin
    wr_idx    = pop ? count - 2'd1 : count;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  // shift on pop first; a same-cycle push lands after the shift and wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < PREFETCH_DEPTH; i++) slot[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < PREFETCH_DEPTH - 1; i++) slot[i] <= slot[i+1];
      end
      if (push) slot[wr_idx] <= push_data;
      count <= count_nxt;
    end
  end

  assign head  = slot[0];
  assign valid = (count != '0);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller over an external 2-cycle-latency simple-dual-port BRAM.
// Define BRAM_FIFO_LEVEL_EN to build the fill_level / almost_full logic.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_write_address,
  output logic [ADDR_WIDTH-1:0] bram_read_address,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]        count, count_nxt;
  logic [BRAM_RD_LATENCY-1:0] tag;
  logic [PF_CNT_W-1:0]        pf_count;
  logic [2:0]                 pending;
  logic                       wr, rd, pop;

  assign in_ready = !rst && (count != FULL_CNT);
  assign wr       = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign pending  = {2'b0, tag[0]} + {2'b0, tag[1]} + {1'b0, pf_count};
  // the word leaving this cycle frees its slot, so reads keep up with a
  // consumer that takes one word per cycle; count excludes this cycle's write
  assign rd        = !rst && (count != '0) && (pending < 3'd3 + {2'b0, pop});
  assign count_nxt = count + {{ADDR_WIDTH{1'b0}}, wr} - {{ADDR_WIDTH{1'b0}}, rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tag    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      tag   <= {tag[BRAM_RD_LATENCY-2:0], rd};
    end
  end

  assign bram_en            = !rst;
  assign bram_we            = wr;
  assign bram_write_address = wr_ptr;
  assign bram_data_in       = in_data;
  assign bram_read_address  = rd_ptr;

  bram_fifo_prefetch #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prefetch (
    .clk      (clk),
    .rst      (rst),
    .push     (tag[BRAM_RD_LATENCY-1]),
    .push_data(bram_data_out),
    .pop      (pop),
    .head     (out_data),
    .valid    (out_valid),
    .count    (pf_count)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_TH = FULL_CNT - (ADDR_WIDTH+1)'(AFULL_MARGIN);

  logic [PF_CNT_W-1:0] pf_nxt;
  logic [ADDR_WIDTH:0] level_nxt;

  // level registered from next-state terms so it matches the current contents
  always_comb begin
    pf_nxt    = pf_count + {1'b0, tag[BRAM_RD_LATENCY-1]} - {1'b0, pop};
    level_nxt = count_nxt + (ADDR_WIDTH+1)'(rd) + (ADDR_WIDTH+1)'(tag[0])
              + (ADDR_WIDTH+1)'(pf_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      fill_level  <= level_nxt;
      almost_full <= (level_nxt >= AFULL_TH);
    end
  end
`else
  assign fill_level  = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl (ADDR_WIDTH=4) with a behavioural
// 2-cycle-latency BRAM; level checks follow BRAM_FIFO_LEVEL_EN.
module tb_bram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_write_address, bram_read_address;
  logic [DW-1:0] bram_data_in, bram_data_out;
  logic [AW:0]   fill_level;
  logic          almost_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bram_en(bram_en), .bram_we(bram_we),
    .bram_write_address(bram_write_address), .bram_read_address(bram_read_address),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
    .fill_level(fill_level), .almost_full(almost_full)
  );

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_write_address] <= bram_data_in;
    if (bram_en) begin
      rd_s1         <= mem[bram_read_address];
      bram_data_out <= rd_s1;
    end
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          orr;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: random stalls both sides; 1: out_ready toggles, input continuous;
  // 2: fill to capacity, drain, then refill across the pointer wrap
  task automatic run_stream(input int n, input int mode, input logic [DW-1:0] base);
    int sent = 0, recv = 0, cyc = 0;
    logic hold = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic ivv, orv, s_ir, s_ov;
    logic [DW-1:0] s_od;
    while (recv < n && cyc < 3000) begin
      @(negedge clk);
      case (mode)
        0: begin
          ivv = (sent < n) && ($urandom_range(0, 3) != 0);
          orv = ($urandom_range(0, 2) != 0);
        end
        1: begin
          ivv = (sent < n);
          orv = (cyc % 2) == 1;
        end
        default: begin
          ivv = (sent < 19) || (recv >= 19 && sent < n);
          orv = (sent >= 19);
        end
      endcase
      in_valid = ivv; in_data = base + sent; out_ready = orv;
      #1;
      s_ir = in_ready; s_ov = out_valid; s_od = out_data;
      if (hold) begin
        check("hold_valid", s_ov, 1);
        check("hold_data", s_od, hold_d);
      end
      @(posedge clk);
      if (ivv && s_ir) sent++;
      if (s_ov && orv) begin
        check("stream_data", s_od, base + recv);
        recv++;
      end
      hold = s_ov && !orv;
      hold_d = s_od;
      cyc++;
    end
    check("stream_count", recv, n);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_fill_level", fill_level, 0);
    check("rst_almost_full", almost_full, 0);
    rst = 1'b0;

    tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11111111};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11111111};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h11111111};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h22222222};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h33333333};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].orr;
      #1;
      check("vec_in_ready", in_ready, tbl[i].e_ir);
      check("vec_out_valid", out_valid, tbl[i].e_ov);
      check("vec_bram_we", bram_we, tbl[i].iv & tbl[i].e_ir);
      if (tbl[i].e_ov) check("vec_out_data", out_data, tbl[i].e_od);
    end

    // capacity: 16 BRAM words + 3 prefetch words with the consumer stalled
    do_reset();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      logic s_ir;
      @(negedge clk);
      in_valid = 1'b1; in_data = acc; out_ready = 1'b0;
      #1;
      s_ir = in_ready;
`ifdef BRAM_FIFO_LEVEL_EN
      check("afull_vs_level", almost_full, fill_level >= 12);
`else
      check("level_tied", {fill_level, almost_full}, 0);
`endif
      @(posedge clk);
      if (s_ir) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("cap_accepted", acc, 19);
    check("cap_in_ready", in_ready, 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("cap_fill_level", fill_level, 19);
    check("cap_almost_full", almost_full, 1);
`endif
    acc = 0;
    for (int c = 0; c < 60 && acc < 19; c++) begin
      logic s_ov;
      logic [DW-1:0] s_od;
      @(negedge clk);
      out_ready = 1'b1; #1;
      s_ov = out_valid; s_od = out_data;
      @(posedge clk);
      if (s_ov) begin
        check("cap_drain_data", s_od, acc);
        acc++;
      end
    end
    check("cap_drain_count", acc, 19);

    do_reset();
    run_stream(100, 0, 32'h0);
    do_reset();
    run_stream(40, 2, 32'h1000);
    do_reset();
    run_stream(30, 1, 32'h2000);

    // reset with words held in BRAM, in flight and in the prefetch buffer
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hA0 + c; out_ready = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hBB;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_out_data", out_data, 32'hA2);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_bram_we", bram_we, 0);
    check("mid_rst_bram_en", bram_en, 0);
    check("mid_rst_level", {fill_level, almost_full}, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("post_rst_empty", seen, 0);
    run_stream(5, 0, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
